rtc_bus_responder: RTL and testbench

Device-side end of the multiplexed 8-bit RTC bus that the master-side bidirectional pad buffer drives.
- Decodes an address phase and a data phase on a shared address/data bus.
- Serves reads by driving the bus, and commits writes into a small register file.
- Keeps BCD seconds, minutes and hours advancing from a 1 Hz tick.
- Used as the RTC model in system benches and as an on-FPGA stand-in when the real RTC is absent.

---
 rtl/rtc_bus_pkg.sv | 31 +++
 rtl/rtc_bus_responder_if.sv | 27 ++
 rtl/bcd_time_counter.sv | 53 +++++
 rtl/rtc_bus_responder.sv | 114 +++++++++++
 tb/tb_rtc_bus_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared constants, bus phase encoding and BCD increment helper for the RTC bus responder.
package rtc_bus_pkg;

    localparam logic [7:0] SEC_ADDR_DEF  = 8'h00;
    localparam logic [7:0] MIN_ADDR_DEF  = 8'h01;
    localparam logic [7:0] HOUR_ADDR_DEF = 8'h02;
    localparam logic [7:0] CTRL_ADDR_DEF = 8'h0F;

    localparam logic [7:0] SEC_MIN_LIMIT = 8'h59;
    localparam logic [7:0] HOUR_LIMIT    = 8'h23;

    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_e;

    // Returns {carry, next}; at or above the limit wraps to zero with carry,
    // a low digit of 9 or a non-BCD digit rolls into the high digit.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
        logic [8:0] r;
        if (v >= limit) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] >= 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// Multiplexed 8-bit RTC bus: strobes, shared address/data wires and both tri-state drivers.
interface rtc_bus_responder_if;

    logic       cs_n;
    logic       ad_sel;
    logic       rd_n;
    logic       wr_n;
    logic       drive_en;
    logic [7:0] dout;
    logic       m_oe;
    logic [7:0] m_data;
    tri   [7:0] bidir;

    assign bidir = drive_en ? dout : 'z;
    assign bidir = m_oe ? m_data : 'z;

    modport slave (
        input  cs_n, ad_sel, rd_n, wr_n, bidir,
        output drive_en, dout
    );

    modport master (
        output cs_n, ad_sel, rd_n, wr_n, m_oe, m_data,
        input  drive_en, bidir
    );

endinterface

// File: rtl/bcd_time_counter.sv
// BCD seconds/minutes/hours advanced by a 1 Hz tick; bus writes override the tick per register.
module bcd_time_counter
    import rtc_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       halt,
    input  logic       wr_sec,
    input  logic       wr_min,
    input  logic       wr_hour,
    input  logic [7:0] wr_data,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour
);

    logic       adv;
    logic       sec_c, min_c, hour_c;
    logic [7:0] sec_n, min_n, hour_n;

    always_comb begin
        adv              = tick & ~halt;
        {sec_c, sec_n}   = bcd_inc(sec, SEC_MIN_LIMIT);
        {min_c, min_n}   = bcd_inc(min, SEC_MIN_LIMIT);
        {hour_c, hour_n} = bcd_inc(hour, HOUR_LIMIT);
    end

    // Carries come from the pre-write values, so a write only suppresses its own increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec  <= '0;
            min  <= '0;
            hour <= '0;
        end else begin
            if (wr_sec)
                sec <= wr_data;
            else if (adv)
                sec <= sec_n;

            if (wr_min)
                min <= wr_data;
            else if (adv && sec_c)
                min <= min_n;

            if (wr_hour)
                hour <= wr_data;
            else if (adv && sec_c && min_c)
                hour <= hour_c ? '0 : hour_n;
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// Device end of the multiplexed RTC bus: samples the pins, latches address, commits writes, drives reads.
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int unsigned REG_COUNT = 16,
    parameter logic [7:0]  SEC_ADDR  = SEC_ADDR_DEF,
    parameter logic [7:0]  MIN_ADDR  = MIN_ADDR_DEF,
    parameter logic [7:0]  HOUR_ADDR = HOUR_ADDR_DEF,
    parameter logic [7:0]  CTRL_ADDR = CTRL_ADDR_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    rtc_bus_responder_if.slave  bus,
    output logic [7:0]          addr_q
);

    logic       s_cs_n, s_rd_n, s_wr_n;
    phase_e     s_phase;
    logic [7:0] s_data;
    logic       p_cs_n, p_wr_n;
    phase_e     p_phase;
    logic [7:0] p_data;

    logic [7:0] regs [16];
    logic [7:0] sec, min, hour;
    logic [7:0] rd_data;
    logic       commit, addr_wr, data_wr, read_req, halt;
    logic       wr_sec, wr_min, wr_hour;

    function automatic logic implemented(input logic [7:0] a);
        return 32'(a) < REG_COUNT;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_cs_n  <= 1'b1;
            s_phase <= PH_ADDR;
            s_rd_n  <= 1'b1;
            s_wr_n  <= 1'b1;
            s_data  <= '0;
            p_cs_n  <= 1'b1;
            p_phase <= PH_ADDR;
            p_wr_n  <= 1'b1;
            p_data  <= '0;
        end else begin
            s_cs_n  <= bus.cs_n;
            s_phase <= phase_e'(bus.ad_sel);
            s_rd_n  <= bus.rd_n;
            s_wr_n  <= bus.wr_n;
            s_data  <= bus.bidir;
            p_cs_n  <= s_cs_n;
            p_phase <= s_phase;
            p_wr_n  <= s_wr_n;
            p_data  <= s_data;
        end
    end

    // Commit on the sampled wr_n rise, using phase/data from the last strobe-low cycle.
    always_comb begin
        commit   = ~p_wr_n & s_wr_n & ~p_cs_n;
        addr_wr  = commit & (p_phase == PH_ADDR);
        data_wr  = commit & (p_phase == PH_DATA) & implemented(addr_q);
        read_req = ~s_cs_n & (s_phase == PH_DATA) & ~s_rd_n & s_wr_n;
        halt     = implemented(CTRL_ADDR) & regs[CTRL_ADDR[3:0]][0];
        rd_data  = '0;
        if (implemented(addr_q)) begin
            if (addr_q == SEC_ADDR)
                rd_data = sec;
            else if (addr_q == MIN_ADDR)
                rd_data = min;
            else if (addr_q == HOUR_ADDR)
                rd_data = hour;
            else
                rd_data = regs[addr_q[3:0]];
        end
    end

    assign wr_sec  = data_wr & (addr_q == SEC_ADDR);
    assign wr_min  = data_wr & (addr_q == MIN_ADDR);
    assign wr_hour = data_wr & (addr_q == HOUR_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            regs         <= '{default: '0};
            bus.drive_en <= 1'b0;
            bus.dout     <= '0;
        end else begin
            if (addr_wr)
                addr_q <= p_data;
            if (data_wr)
                regs[addr_q[3:0]] <= p_data;
            bus.drive_en <= read_req;
            if (read_req)
                bus.dout <= rd_data;
        end
    end

    bcd_time_counter u_time (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .halt    (halt),
        .wr_sec  (wr_sec),
        .wr_min  (wr_min),
        .wr_hour (wr_hour),
        .wr_data (p_data),
        .sec     (sec),
        .min     (min),
        .hour    (hour)
    );

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed plus randomized bench for rtc_bus_responder (REG_COUNT 16 and 4) against a register-file model.
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       cs_n = 1'b1, ad_sel = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
    logic       m_oe = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] addr_q0, addr_q1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0]  m_regs [2][16];
    int unsigned m_rc [2] = '{16, 4};
    logic [7:0]  m_addr;

    always #5 clk = ~clk;

    rtc_bus_responder_if bus0 ();
    rtc_bus_responder_if bus1 ();

    assign bus0.cs_n = cs_n;   assign bus1.cs_n = cs_n;
    assign bus0.ad_sel = ad_sel; assign bus1.ad_sel = ad_sel;
    assign bus0.rd_n = rd_n;   assign bus1.rd_n = rd_n;
    assign bus0.wr_n = wr_n;   assign bus1.wr_n = wr_n;
    assign bus0.m_oe = m_oe;   assign bus1.m_oe = m_oe;
    assign bus0.m_data = m_data; assign bus1.m_data = m_data;

    rtc_bus_responder #(.REG_COUNT(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus0), .addr_q(addr_q0)
    );

    rtc_bus_responder #(.REG_COUNT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus1), .addr_q(addr_q1)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] m_inc(input logic [7:0] v, input logic [7:0] lim);
        int unsigned hi, lo;
        hi = int'(v) / 16;
        lo = int'(v) % 16;
        if (v >= lim) return {1'b1, 8'h00};
        if (lo >= 9) return {1'b0, 8'((hi + 1) * 16)};
        return {1'b0, v + 8'd1};
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++)
                m_regs[d][a] = 8'h00;
        m_addr = 8'h00;
    endfunction

    function automatic void m_tick();
        logic [8:0] r;
        for (int d = 0; d < 2; d++) begin
            if (m_rc[d] > 15 && m_regs[d][15][0]) continue;
            r = m_inc(m_regs[d][0], 8'h59);
            m_regs[d][0] = r[7:0];
            if (r[8]) begin
                r = m_inc(m_regs[d][1], 8'h59);
                m_regs[d][1] = r[7:0];
                if (r[8]) begin
                    r = m_inc(m_regs[d][2], 8'h23);
                    m_regs[d][2] = r[7:0];
                end
            end
        end
    endfunction

    function automatic void m_write(input logic ad, input logic [7:0] d);
        if (!ad) m_addr = d;
        else
            for (int k = 0; k < 2; k++)
                if (int'(m_addr) < int'(m_rc[k])) m_regs[k][m_addr[3:0]] = d;
    endfunction

    function automatic logic [7:0] m_read(input int d);
        if (int'(m_addr) < int'(m_rc[d])) return m_regs[d][m_addr[3:0]];
        return 8'h00;
    endfunction

    task automatic bus_write(input logic ad, input logic [7:0] d, input logic with_tick);
        cs_n = 1'b0; ad_sel = ad; m_oe = 1'b1; m_data = d; wr_n = 1'b0;
        cyc();
        wr_n = 1'b1;
        cyc();
        tick = with_tick;
        cyc();
        tick = 1'b0;
        if (with_tick) m_tick();
        m_write(ad, d);
        cs_n = 1'b1; m_oe = 1'b0;
        cyc();
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        bus_write(1'b0, a, 1'b0);
        bus_write(1'b1, d, 1'b0);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        m_tick();
    endtask

    task automatic do_read(input string tag);
        chk({tag, "_addr0"}, addr_q0, m_addr);
        chk({tag, "_addr1"}, addr_q1, m_addr);
        cs_n = 1'b0; ad_sel = 1'b1; rd_n = 1'b0;
        cyc();
        chk({tag, "_early"}, {7'd0, bus0.drive_en}, 8'h00);
        cyc();
        chk({tag, "_drv0"}, {7'd0, bus0.drive_en}, 8'h01);
        chk({tag, "_drv1"}, {7'd0, bus1.drive_en}, 8'h01);
        chk({tag, "_data0"}, bus0.bidir, m_read(0));
        chk({tag, "_data1"}, bus1.bidir, m_read(1));
        rd_n = 1'b1;
        cyc();
        chk({tag, "_hold"}, {7'd0, bus0.drive_en}, 8'h01);
        cyc();
        chk({tag, "_rel0"}, {7'd0, bus0.drive_en}, 8'h00);
        chk({tag, "_rel1"}, {7'd0, bus1.drive_en}, 8'h00);
        cs_n = 1'b1;
        cyc();
    endtask

    task automatic read_at(input logic [7:0] a, input string tag);
        bus_write(1'b0, a, 1'b0);
        do_read(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned op;
        logic [7:0]  ra, rd;

        m_reset();
        cyc(); cyc();
        chk("rst_drive", {7'd0, bus0.drive_en}, 8'h00);
        chk("rst_addr", addr_q0, 8'h00);
        rst_n = 1'b1;
        cyc();

        // Write then read at 0x05 (unimplemented on the 4-register instance)
        write_reg(8'h05, 8'hA7);
        read_at(8'h05, "wr_rd_05");

        write_reg(8'h08, 8'hFF);
        read_at(8'h08, "unimpl_08");

        // Rollover of all three time registers in one tick
        write_reg(8'h00, 8'h59);
        write_reg(8'h01, 8'h59);
        write_reg(8'h02, 8'h23);
        tick_pulse();
        read_at(8'h00, "roll_sec");
        read_at(8'h01, "roll_min");
        read_at(8'h02, "roll_hour");

        // Halt via CTRL bit0 (only effective where CTRL is implemented)
        write_reg(8'h00, 8'h17);
        write_reg(8'h0F, 8'h01);
        for (int i = 0; i < 10; i++) tick_pulse();
        read_at(8'h00, "halt_sec");
        write_reg(8'h0F, 8'h00);
        tick_pulse();
        read_at(8'h00, "unhalt_sec");

        // Write/tick collisions
        write_reg(8'h00, 8'h12);
        bus_write(1'b0, 8'h00, 1'b0);
        bus_write(1'b1, 8'h30, 1'b1);
        do_read("coll_sec");
        write_reg(8'h00, 8'h59);
        write_reg(8'h01, 8'h10);
        bus_write(1'b0, 8'h00, 1'b0);
        bus_write(1'b1, 8'h05, 1'b1);
        do_read("coll_sec2");
        read_at(8'h01, "coll_min_carry");

        // Both strobes low: no drive; the later wr_n rise still commits
        bus_write(1'b0, 8'h03, 1'b0);
        cs_n = 1'b0; ad_sel = 1'b1; m_oe = 1'b1; m_data = 8'h5A; rd_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("conflict_nodrive", {7'd0, bus0.drive_en}, 8'h00);
        end
        rd_n = 1'b1; wr_n = 1'b1;
        cyc();
        chk("conflict_rise", {7'd0, bus0.drive_en}, 8'h00);
        cyc();
        m_write(1'b1, 8'h5A);
        cs_n = 1'b1; m_oe = 1'b0;
        cyc();
        do_read("conflict_commit");

        // Read strobe during the address phase never drives
        cs_n = 1'b0; ad_sel = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("addr_phase_read", {7'd0, bus0.drive_en}, 8'h00);
        end
        rd_n = 1'b1; cs_n = 1'b1;
        cyc();

        // Randomized mix of writes, ticks, reads and collisions
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            ra = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            rd = 8'($urandom);
            case (op)
                0: write_reg(ra, rd);
                1: for (int k = 0; k < int'($urandom_range(1, 3)); k++) tick_pulse();
                2: read_at(ra, "rand_read");
                default: begin
                    bus_write(1'b0, 8'($urandom_range(0, 2)), 1'b0);
                    bus_write(1'b1, rd, 1'b1);
                    do_read("rand_coll");
                end
            endcase
        end

        // Reset in the middle of a read releases the bus at once
        write_reg(8'h06, 8'hC3);
        cs_n = 1'b0; ad_sel = 1'b1; rd_n = 1'b0;
        cyc(); cyc();
        chk("midrd_drive", {7'd0, bus0.drive_en}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("midrd_rst0", {7'd0, bus0.drive_en}, 8'h00);
        chk("midrd_rst1", {7'd0, bus1.drive_en}, 8'h00);
        chk("midrd_addr", addr_q0, 8'h00);
        m_reset();
        cs_n = 1'b1; rd_n = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        read_at(8'h00, "post_rst_sec");
        read_at(8'h02, "post_rst_hour");
        read_at(8'h06, "post_rst_06");
        read_at(8'h0F, "post_rst_ctrl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
